pc_seq: RTL

- Parametrised program-counter sequencer for the fetch stage.
- Generalises the basic PC register with configurable width, step and branch offset.
- Adds a return-address stack (RAS) for branch-with-link / return.
- Adds a refill-bubble counter that marks fetch addresses invalid for a fixed number of cycles after any non-sequential PC change.
- Feeds instruction memory; the execute stage drives the branch, redirect and return controls.

---
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pc_seq_if.sv
// Fetch-stage control/result bundle between the execute stage and the PC sequencer.
// The master modport is the driver side; the slave modport is the sequencer side.
interface pc_seq_if #(
  parameter int WIDTH = 32
);
  logic             mod_en;
  logic             r_en;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic             ib;
  logic [WIDTH-1:0] bv;
  logic             link;
  logic             ret;
  logic [WIDTH-1:0] iaddrout;
  logic             iaddr_valid;
  logic             ras_empty;
  logic             ras_full;
  logic [1:0]       ras_err;

  modport master (
    output mod_en, r_en, we, wd, ib, bv, link, ret,
    input  iaddrout, iaddr_valid, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  mod_en, r_en, we, wd, ib, bv, link, ret,
    output iaddrout, iaddr_valid, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: redirect / return / branch / sequential next-PC selection,
// a circular return-address stack, and a refill-bubble counter gating fetch validity.
module pc_seq #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter int               BR_OFFSET    = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR   = '0,
  parameter int               RAS_DEPTH    = 4,
  parameter int               FLUSH_CYCLES = 2
) (
  input logic   clk,
  input logic   reset,
  pc_seq_if.slave bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int BW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] BROFF_W = WIDTH'(BR_OFFSET);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [BW-1:0]    FLUSH_B = BW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_RET,
    SEL_BR
  } pc_sel_e;

  logic [WIDTH-1:0] ctr;
  logic [WIDTH-1:0] ctr_next;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;      // next slot to write; top lives at ras_ptr - 1
  logic [PW-1:0]    ras_ptr_dec;
  logic [CW-1:0]    ras_cnt;
  logic [BW-1:0]    bcnt;
  logic [1:0]       ras_err_q;

  pc_sel_e pc_sel;
  logic    do_push;
  logic    do_pop;
  logic    underflow;
  logic    full;
  logic    empty;

  assign seq_addr    = ctr + STEP_W;
  assign ras_ptr_dec = ras_ptr - PW'(1);
  assign full        = (ras_cnt == DEPTH_C);
  assign empty       = (ras_cnt == '0);

  // Next-PC source selection: redirect beats return beats branch beats sequential.
  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_sel    = SEL_SEQ;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    underflow = 1'b0;
    if (bus.we) begin
      pc_sel = SEL_REDIR;
    end else if (bus.ret) begin
      if (!empty) begin
        pc_sel = SEL_RET;
        do_pop = 1'b1;
      end else begin
        underflow = 1'b1;
      end
    end else if (bus.ib) begin
      pc_sel  = SEL_BR;
      do_push = bus.link;
    end
  end

  always_comb begin
    ctr_next = seq_addr;
    unique case (pc_sel)
      SEL_REDIR: ctr_next = bus.wd;
      SEL_RET:   ctr_next = ras_mem[ras_ptr_dec];
      SEL_BR:    ctr_next = ctr + bus.bv + BROFF_W;
      default:   ctr_next = seq_addr;
    endcase
  end

  // Architectural state; everything except the output register freezes when mod_en is low.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr       <= RESET_ADDR;
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      ras_err_q <= 2'b00;
      bcnt      <= FLUSH_B;
    end else if (bus.mod_en) begin
      ctr <= ctr_next;

      if (do_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (full) ras_err_q[0] <= 1'b1;
        else      ras_cnt      <= ras_cnt + CW'(1);
      end else if (do_pop) begin
        ras_ptr <= ras_ptr_dec;
        ras_cnt <= ras_cnt - CW'(1);
      end

      if (underflow) ras_err_q[1] <= 1'b1;

      if (pc_sel != SEL_SEQ) bcnt <= FLUSH_B;
      else if (bcnt != '0)   bcnt <= bcnt - BW'(1);
    end
  end

  // NOTE: the stack storage has no reset; ras_cnt guards every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (!reset && bus.mod_en && do_push) begin
      ras_mem[ras_ptr] <= seq_addr;
    end
  end

  // Fetch output register samples the pre-update PC and bubble state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.iaddrout    <= RESET_ADDR;
      bus.iaddr_valid <= 1'b0;
    end else if (bus.r_en) begin
      bus.iaddrout    <= ctr;
      bus.iaddr_valid <= (bcnt == '0);
    end
  end

  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = ras_err_q;

endmodule
